aq_fdsu_special_mlane: RTL and testbench

- Multi-lane, multi-format special-case front end for the FDSU divide/sqrt datapath.
- Each lane decodes raw operands for half, bf16, single or double, applies IEEE div/sqrt special rules and builds the NaN result.
- Results sit in one registered EX2 stage with valid/ready backpressure and flush.
- Sticky NV/DZ flags accumulate across retired ops; the SRT core consumes the per-lane skip and result selects.

---
 rtl/aq_fdsu_special_pkg.sv | 55 +++++
 rtl/aq_fdsu_special_lane.sv | 163 ++++++++++++++++
 rtl/aq_fdsu_special_mlane.sv | 125 ++++++++++++
 tb/tb_aq_fdsu_special_mlane.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_fdsu_special_pkg.sv
// Shared encodings, field widths and result types for the FDSU special-case front end.
// Optional bf16 decode is enabled by defining AQ_FDSU_SPECIAL_BF16_EN.
package aq_fdsu_special_pkg;

    localparam logic [1:0] FMT_HALF   = 2'b00;
    localparam logic [1:0] FMT_BF16   = 2'b01;
    localparam logic [1:0] FMT_SINGLE = 2'b10;
    localparam logic [1:0] FMT_DOUBLE = 2'b11;

    localparam int H_EXP_W  = 5;
    localparam int H_MANT_W = 10;
    localparam int B_EXP_W  = 8;
    localparam int B_MANT_W = 7;
    localparam int S_EXP_W  = 8;
    localparam int S_MANT_W = 23;
    localparam int D_EXP_W  = 11;
    localparam int D_MANT_W = 52;

    localparam int QNAN_W = 53;

    // Double-precision canonical qNaN in {sign, quiet, payload} form.
    localparam logic [QNAN_W-1:0] QNAN_CANON = 53'h8000000000000;

    typedef struct packed {
        logic              zero;
        logic              inf;
        logic              qnan;
        logic              nv;
        logic              dz;
        logic              skip;
        logic [QNAN_W-1:0] qnan_f;
    } lane_res_t;

    typedef struct packed {
        logic              sign;
        logic              inf;
        logic              zero;
        logic              norm;
        logic              nan;
        logic              snan;
        logic              qnan;
        logic [QNAN_W-1:0] nan_f;
    } opnd_cls_t;

    // Canonical qNaN low-aligned to the width of the selected format.
    function automatic logic [QNAN_W-1:0] canon_nan(input logic [1:0] fmt);
        case (fmt)
            FMT_HALF:   return 53'd1 << (H_MANT_W - 1);
            FMT_BF16:   return 53'd1 << (B_MANT_W - 1);
            FMT_SINGLE: return 53'd1 << (S_MANT_W - 1);
            default:    return QNAN_CANON;
        endcase
    endfunction

endpackage

// File: rtl/aq_fdsu_special_lane.sv
// One lane of operand classification, IEEE div/sqrt special rules and NaN selection.
// Fully combinational; bf16 decode exists only when AQ_FDSU_SPECIAL_BF16_EN is defined.
module aq_fdsu_special_lane
    import aq_fdsu_special_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            lane_en_i,
    input  logic            div_i,
    input  logic            sqrt_i,
    input  logic [1:0]      fmt_i,
    input  logic            dqnan_i,
    input  logic [XLEN-1:0] oper0_i,
    input  logic [XLEN-1:0] oper1_i,
    output lane_res_t       res_o
);

    localparam int PW = (XLEN > 64) ? XLEN : 64;

    logic [PW-1:0] op0_w;
    logic [PW-1:0] op1_w;
    opnd_cls_t     c0;
    opnd_cls_t     c1;
    logic          fmt_ok;
    logic          dflt;
    lane_res_t     res;

    assign op0_w = PW'(oper0_i);
    assign op1_w = PW'(oper1_i);

    function automatic logic boxed_above(input logic [PW-1:0] v, input int lo);
        logic r;
        r = 1'b1;
        for (int i = 0; i < PW; i++) begin
            if (i >= lo && i < XLEN) r = r & v[i];
        end
        return r;
    endfunction

    function automatic opnd_cls_t classify(input logic [PW-1:0] op, input logic [1:0] fmt);
        opnd_cls_t         c;
        logic              e_ones;
        logic              e_zero;
        logic              m_zero;
        logic              m_msb;
        logic              boxed;
        logic [QNAN_W-1:0] f;
        c      = '0;
        e_ones = 1'b0;
        e_zero = 1'b0;
        m_zero = 1'b0;
        m_msb  = 1'b0;
        boxed  = 1'b0;
        f      = '0;
        case (fmt)
            FMT_HALF: begin
                c.sign = op[H_EXP_W+H_MANT_W];
                e_ones = &op[H_EXP_W+H_MANT_W-1:H_MANT_W];
                e_zero = ~|op[H_EXP_W+H_MANT_W-1:H_MANT_W];
                m_zero = ~|op[H_MANT_W-1:0];
                m_msb  = op[H_MANT_W-1];
                f      = QNAN_W'({op[H_EXP_W+H_MANT_W], 1'b1, op[H_MANT_W-2:0]});
                boxed  = boxed_above(op, 16);
            end
`ifdef AQ_FDSU_SPECIAL_BF16_EN
            FMT_BF16: begin
                c.sign = op[B_EXP_W+B_MANT_W];
                e_ones = &op[B_EXP_W+B_MANT_W-1:B_MANT_W];
                e_zero = ~|op[B_EXP_W+B_MANT_W-1:B_MANT_W];
                m_zero = ~|op[B_MANT_W-1:0];
                m_msb  = op[B_MANT_W-1];
                f      = QNAN_W'({op[B_EXP_W+B_MANT_W], 1'b1, op[B_MANT_W-2:0]});
                boxed  = boxed_above(op, 16);
            end
`endif
            FMT_SINGLE: begin
                c.sign = op[S_EXP_W+S_MANT_W];
                e_ones = &op[S_EXP_W+S_MANT_W-1:S_MANT_W];
                e_zero = ~|op[S_EXP_W+S_MANT_W-1:S_MANT_W];
                m_zero = ~|op[S_MANT_W-1:0];
                m_msb  = op[S_MANT_W-1];
                f      = QNAN_W'({op[S_EXP_W+S_MANT_W], 1'b1, op[S_MANT_W-2:0]});
                boxed  = boxed_above(op, 32);
            end
            FMT_DOUBLE: begin
                c.sign = op[D_EXP_W+D_MANT_W];
                e_ones = &op[D_EXP_W+D_MANT_W-1:D_MANT_W];
                e_zero = ~|op[D_EXP_W+D_MANT_W-1:D_MANT_W];
                m_zero = ~|op[D_MANT_W-1:0];
                m_msb  = op[D_MANT_W-1];
                f      = QNAN_W'({op[D_EXP_W+D_MANT_W], 1'b1, op[D_MANT_W-2:0]});
                boxed  = 1'b1;
            end
            default: begin
                boxed = 1'b1;
            end
        endcase
        // A badly boxed operand behaves as a quiet NaN that can only yield the canonical value.
        if (!boxed) begin
            c.nan   = 1'b1;
            c.qnan  = 1'b1;
            c.nan_f = canon_nan(fmt);
        end else begin
            c.inf   = e_ones & m_zero;
            c.nan   = e_ones & ~m_zero;
            c.qnan  = e_ones & ~m_zero & m_msb;
            c.snan  = e_ones & ~m_zero & ~m_msb;
            c.zero  = e_zero & m_zero;
            c.norm  = ~(e_ones | (e_zero & m_zero));
            c.nan_f = f;
        end
        return c;
    endfunction

    always_comb begin
        fmt_ok = 1'b0;
        case (fmt_i)
            FMT_HALF:   fmt_ok = 1'b1;
`ifdef AQ_FDSU_SPECIAL_BF16_EN
            FMT_BF16:   fmt_ok = 1'b1;
`endif
            FMT_SINGLE: fmt_ok = 1'b1;
            FMT_DOUBLE: fmt_ok = (XLEN >= 64);
            default:    fmt_ok = 1'b0;
        endcase
    end

    always_comb begin
        c0   = classify(op0_w, fmt_i);
        c1   = classify(op1_w, fmt_i);
        res  = '0;
        dflt = 1'b0;
        if (lane_en_i && fmt_ok && (sqrt_i || div_i)) begin
            if (sqrt_i) begin
                dflt     = c0.sign & (c0.norm | c0.inf);
                res.nv   = c0.snan | dflt;
                res.zero = c0.zero;
                res.inf  = c0.inf & ~c0.sign;
                res.qnan = res.nv | c0.nan;
            end else begin
                dflt     = (c0.zero & c1.zero) | (c0.inf & c1.inf);
                res.nv   = c0.snan | c1.snan | dflt;
                res.dz   = c1.zero & c0.norm;
                res.zero = (c0.zero & c1.norm) | ((c0.zero | c0.norm) & c1.inf);
                res.inf  = (c0.inf & (c1.zero | c1.norm)) | res.dz;
                res.qnan = res.nv | c0.nan | c1.nan;
            end
            res.skip = res.zero | res.inf | res.qnan;
            // Invalid-operation defaults win over payload propagation; sqrt never looks at op1.
            if (res.qnan) begin
                if (dflt || !dqnan_i)          res.qnan_f = canon_nan(fmt_i);
                else if (c0.snan)              res.qnan_f = c0.nan_f;
                else if (div_i && c1.snan)     res.qnan_f = c1.nan_f;
                else if (c0.qnan)              res.qnan_f = c0.nan_f;
                else if (div_i && c1.qnan)     res.qnan_f = c1.nan_f;
                else                           res.qnan_f = canon_nan(fmt_i);
            end
        end
    end

    assign res_o = res;

endmodule

// File: rtl/aq_fdsu_special_mlane.sv
// Multi-lane FDSU special-case front end: per-lane decode, EX2 register with handshake and sticky flags.
// bf16 support is selected at build time with AQ_FDSU_SPECIAL_BF16_EN.
module aq_fdsu_special_mlane
    import aq_fdsu_special_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 64
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    ex1_vld,
    output logic                    ex1_rdy,
    input  logic                    ex1_div,
    input  logic                    ex1_sqrt,
    input  logic [1:0]              ex1_fmt,
    input  logic [LANES-1:0]        ex1_lane_mask,
    input  logic [LANES*XLEN-1:0]   ex1_oper0,
    input  logic [LANES*XLEN-1:0]   ex1_oper1,
    input  logic                    cp0_vpu_xx_dqnan,
    input  logic                    ex1_flush,
    output logic                    ex2_vld,
    input  logic                    ex2_rdy,
    output logic [LANES-1:0]        ex2_srt_skip,
    output logic [LANES-1:0]        ex2_rst_zero,
    output logic [LANES-1:0]        ex2_rst_inf,
    output logic [LANES-1:0]        ex2_rst_qnan,
    output logic [LANES-1:0]        ex2_nv_lane,
    output logic [LANES-1:0]        ex2_dz_lane,
    output logic [LANES*QNAN_W-1:0] ex2_qnan_f,
    output logic                    ex2_nv,
    output logic                    ex2_dz,
    input  logic                    fflags_clr,
    output logic                    fflags_nv_acc,
    output logic                    fflags_dz_acc
);

    lane_res_t lane_res [LANES];
    lane_res_t res_q    [LANES];
    logic      vld_q;
    logic      vld_d;
    logic      nv_acc_q;
    logic      nv_acc_d;
    logic      dz_acc_q;
    logic      dz_acc_d;
    logic      capture;
    logic      retire;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aq_fdsu_special_lane #(
            .XLEN(XLEN)
        ) u_lane (
            .lane_en_i (ex1_lane_mask[g]),
            .div_i     (ex1_div),
            .sqrt_i    (ex1_sqrt),
            .fmt_i     (ex1_fmt),
            .dqnan_i   (cp0_vpu_xx_dqnan),
            .oper0_i   (ex1_oper0[g*XLEN +: XLEN]),
            .oper1_i   (ex1_oper1[g*XLEN +: XLEN]),
            .res_o     (lane_res[g])
        );
    end

    assign ex1_rdy = ~vld_q | ex2_rdy;
    assign capture = ex1_vld & ex1_rdy & ~ex1_flush;
    assign retire  = vld_q & ex2_rdy & ~ex1_flush;

    always_comb begin
        vld_d = vld_q;
        if (ex1_flush)     vld_d = 1'b0;
        else if (capture)  vld_d = 1'b1;
        else if (ex2_rdy)  vld_d = 1'b0;
    end

    // A clear in the same cycle as a retire keeps only the retiring op's flags.
    always_comb begin
        nv_acc_d = fflags_clr ? 1'b0 : nv_acc_q;
        dz_acc_d = fflags_clr ? 1'b0 : dz_acc_q;
        if (retire) begin
            nv_acc_d = nv_acc_d | ex2_nv;
            dz_acc_d = dz_acc_d | ex2_dz;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            vld_q    <= 1'b0;
            nv_acc_q <= 1'b0;
            dz_acc_q <= 1'b0;
            for (int i = 0; i < LANES; i++) res_q[i] <= '0;
        end else begin
            vld_q    <= vld_d;
            nv_acc_q <= nv_acc_d;
            dz_acc_q <= dz_acc_d;
            if (capture) begin
                for (int i = 0; i < LANES; i++) res_q[i] <= lane_res[i];
            end
        end
    end

    always_comb begin
        ex2_srt_skip = '0;
        ex2_rst_zero = '0;
        ex2_rst_inf  = '0;
        ex2_rst_qnan = '0;
        ex2_nv_lane  = '0;
        ex2_dz_lane  = '0;
        ex2_qnan_f   = '0;
        for (int i = 0; i < LANES; i++) begin
            ex2_srt_skip[i]              = res_q[i].skip;
            ex2_rst_zero[i]              = res_q[i].zero;
            ex2_rst_inf[i]               = res_q[i].inf;
            ex2_rst_qnan[i]              = res_q[i].qnan;
            ex2_nv_lane[i]               = res_q[i].nv;
            ex2_dz_lane[i]               = res_q[i].dz;
            ex2_qnan_f[i*QNAN_W +: QNAN_W] = res_q[i].qnan_f;
        end
    end

    assign ex2_vld       = vld_q;
    assign ex2_nv        = |ex2_nv_lane;
    assign ex2_dz        = |ex2_dz_lane;
    assign fflags_nv_acc = nv_acc_q;
    assign fflags_dz_acc = dz_acc_q;

endmodule

// File: tb/tb_aq_fdsu_special_mlane.sv
// Directed self-checking bench for aq_fdsu_special_mlane (2 lanes, 64-bit operands).
module tb_aq_fdsu_special_mlane;

    localparam int LANES = 2;
    localparam int XLEN  = 64;

    logic                  clk;
    logic                  cpurst;
    logic                  ex1_vld;
    logic                  ex1_rdy;
    logic                  ex1_div;
    logic                  ex1_sqrt;
    logic [1:0]            ex1_fmt;
    logic [LANES-1:0]      ex1_lane_mask;
    logic [LANES*XLEN-1:0] ex1_oper0;
    logic [LANES*XLEN-1:0] ex1_oper1;
    logic                  dqnan;
    logic                  ex1_flush;
    logic                  ex2_vld;
    logic                  ex2_rdy;
    logic [LANES-1:0]      ex2_srt_skip;
    logic [LANES-1:0]      ex2_rst_zero;
    logic [LANES-1:0]      ex2_rst_inf;
    logic [LANES-1:0]      ex2_rst_qnan;
    logic [LANES-1:0]      ex2_nv_lane;
    logic [LANES-1:0]      ex2_dz_lane;
    logic [LANES*53-1:0]   ex2_qnan_f;
    logic                  ex2_nv;
    logic                  ex2_dz;
    logic                  fflags_clr;
    logic                  fflags_nv_acc;
    logic                  fflags_dz_acc;

    int passCount  = 0;
    int checkCount = 0;

    logic [11:0] flagVec;
    logic [52:0] qnanLane0;
    logic [52:0] qnanLane1;

    assign flagVec   = {ex2_srt_skip, ex2_rst_zero, ex2_rst_inf, ex2_rst_qnan, ex2_nv_lane, ex2_dz_lane};
    assign qnanLane0 = ex2_qnan_f[52:0];
    assign qnanLane1 = ex2_qnan_f[105:53];

    aq_fdsu_special_mlane #(
        .LANES(LANES),
        .XLEN (XLEN)
    ) dut (
        .forever_cpuclk   (clk),
        .cpurst           (cpurst),
        .ex1_vld          (ex1_vld),
        .ex1_rdy          (ex1_rdy),
        .ex1_div          (ex1_div),
        .ex1_sqrt         (ex1_sqrt),
        .ex1_fmt          (ex1_fmt),
        .ex1_lane_mask    (ex1_lane_mask),
        .ex1_oper0        (ex1_oper0),
        .ex1_oper1        (ex1_oper1),
        .cp0_vpu_xx_dqnan (dqnan),
        .ex1_flush        (ex1_flush),
        .ex2_vld          (ex2_vld),
        .ex2_rdy          (ex2_rdy),
        .ex2_srt_skip     (ex2_srt_skip),
        .ex2_rst_zero     (ex2_rst_zero),
        .ex2_rst_inf      (ex2_rst_inf),
        .ex2_rst_qnan     (ex2_rst_qnan),
        .ex2_nv_lane      (ex2_nv_lane),
        .ex2_dz_lane      (ex2_dz_lane),
        .ex2_qnan_f       (ex2_qnan_f),
        .ex2_nv           (ex2_nv),
        .ex2_dz           (ex2_dz),
        .fflags_clr       (fflags_clr),
        .fflags_nv_acc    (fflags_nv_acc),
        .fflags_dz_acc    (fflags_dz_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] fmt, input logic div, input logic sqrt, input logic [1:0] mask,
                         input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] a1,
                         input logic [63:0] b1, input logic dq);
        ex1_fmt       = fmt;
        ex1_div       = div;
        ex1_sqrt      = sqrt;
        ex1_lane_mask = mask;
        ex1_oper0     = {a1, a0};
        ex1_oper1     = {b1, b0};
        dqnan         = dq;
    endtask

    // Presents one op for a single cycle; it sits in EX2 on return.
    task automatic issue(input logic [1:0] fmt, input logic div, input logic sqrt, input logic [1:0] mask,
                         input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] a1,
                         input logic [63:0] b1, input logic dq);
        drive(fmt, div, sqrt, mask, a0, b0, a1, b1, dq);
        ex1_vld = 1'b1;
        tick();
        ex1_vld = 1'b0;
    endtask

    task automatic clear_flags();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        checkCount++;
        if ({fflags_nv_acc, fflags_dz_acc} !== 2'b00)
            $display("[TB] FAIL clear_flags: got %b expected 00", {fflags_nv_acc, fflags_dz_acc});
        else passCount++;
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        ex1_vld = 1'b0; ex1_flush = 1'b0; ex2_rdy = 1'b1; fflags_clr = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
        repeat (3) tick();
        cpurst = 1'b0;
        checkCount++;
        if (ex2_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %b expected 0", ex2_vld); else passCount++;
        checkCount++;
        if (ex1_rdy !== 1'b1) $display("[TB] FAIL reset_rdy: got %b expected 1", ex1_rdy); else passCount++;
        checkCount++;
        if ({fflags_nv_acc, fflags_dz_acc} !== 2'b00)
            $display("[TB] FAIL reset_acc: got %b expected 00", {fflags_nv_acc, fflags_dz_acc});
        else passCount++;
        checkCount++;
        if ({flagVec, ex2_nv, ex2_dz} !== 14'h0) $display("[TB] FAIL reset_flags: got %h expected 0", {flagVec, ex2_nv, ex2_dz});
        else passCount++;
        checkCount++;
        if (ex2_qnan_f !== '0) $display("[TB] FAIL reset_qnan_f: got %h expected 0", ex2_qnan_f); else passCount++;
    endtask

    task automatic test_single_dz();
        issue(2'b10, 1'b1, 1'b0, 2'b01, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_00000000,
              64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 1'b1);
        checkCount++;
        if (ex2_vld !== 1'b1) $display("[TB] FAIL dz_vld: got %b expected 1", ex2_vld); else passCount++;
        checkCount++;
        if (flagVec !== 12'b01_00_01_00_00_01) $display("[TB] FAIL dz_flags: got %b expected %b", flagVec, 12'b01_00_01_00_00_01);
        else passCount++;
        checkCount++;
        if ({ex2_nv, ex2_dz} !== 2'b01) $display("[TB] FAIL dz_nvdz: got %b expected 01", {ex2_nv, ex2_dz}); else passCount++;
        checkCount++;
        if (qnanLane1 !== 53'h0) $display("[TB] FAIL dz_inactive_lane: got %h expected 0", qnanLane1); else passCount++;
        tick();
        checkCount++;
        if (ex2_vld !== 1'b0) $display("[TB] FAIL dz_retire_vld: got %b expected 0", ex2_vld); else passCount++;
        checkCount++;
        if ({fflags_nv_acc, fflags_dz_acc} !== 2'b01)
            $display("[TB] FAIL dz_sticky: got %b expected 01", {fflags_nv_acc, fflags_dz_acc});
        else passCount++;
        clear_flags();
    endtask

    task automatic test_flush();
        issue(2'b10, 1'b1, 1'b0, 2'b01, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_00000000, 64'h0, 64'h0, 1'b1);
        ex1_flush = 1'b1;
        ex1_vld   = 1'b1;
        tick();
        ex1_vld   = 1'b0;
        ex1_flush = 1'b0;
        checkCount++;
        if (ex2_vld !== 1'b0) $display("[TB] FAIL flush_vld: got %b expected 0", ex2_vld); else passCount++;
        checkCount++;
        if (fflags_dz_acc !== 1'b0) $display("[TB] FAIL flush_sticky: got %b expected 0", fflags_dz_acc); else passCount++;
        tick();
        checkCount++;
        if (ex2_vld !== 1'b0) $display("[TB] FAIL flush_drop_capture: got %b expected 0", ex2_vld); else passCount++;
    endtask

    task automatic test_half_sqrt();
        issue(2'b00, 1'b0, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_BC00, 64'h0, 64'h0, 64'h0, 1'b1);
        checkCount++;
        if (flagVec !== 12'b01_00_00_01_01_00) $display("[TB] FAIL hsqrt_flags: got %b expected %b", flagVec, 12'b01_00_00_01_01_00);
        else passCount++;
        checkCount++;
        if (qnanLane0 !== 53'h200) $display("[TB] FAIL hsqrt_qnan_f: got %h expected 200", qnanLane0); else passCount++;
        checkCount++;
        if ({ex2_nv, ex2_dz} !== 2'b10) $display("[TB] FAIL hsqrt_nvdz: got %b expected 10", {ex2_nv, ex2_dz}); else passCount++;
        tick();
    endtask

    task automatic test_double_nan();
        issue(2'b11, 1'b1, 1'b0, 2'b11, 64'h7FF4000000000001, 64'h7FF8000000000000,
              64'h4000000000000000, 64'h7FF8000000000123, 1'b1);
        checkCount++;
        if (flagVec !== 12'b11_00_00_11_01_00) $display("[TB] FAIL dnan_flags: got %b expected %b", flagVec, 12'b11_00_00_11_01_00);
        else passCount++;
        checkCount++;
        if (qnanLane0 !== 53'hC000000000001) $display("[TB] FAIL dnan_snan_payload: got %h expected C000000000001", qnanLane0);
        else passCount++;
        checkCount++;
        if (qnanLane1 !== 53'h8000000000123) $display("[TB] FAIL dnan_qnan1_payload: got %h expected 8000000000123", qnanLane1);
        else passCount++;
        tick();
        issue(2'b11, 1'b1, 1'b0, 2'b11, 64'h7FF4000000000001, 64'h7FF8000000000000,
              64'h4000000000000000, 64'h7FF8000000000123, 1'b0);
        checkCount++;
        if ({qnanLane1, qnanLane0} !== {53'h8000000000000, 53'h8000000000000})
            $display("[TB] FAIL dnan_canon: got %h/%h expected 8000000000000", qnanLane1, qnanLane0);
        else passCount++;
        checkCount++;
        if (ex2_nv_lane !== 2'b01) $display("[TB] FAIL dnan_nv_nodq: got %b expected 01", ex2_nv_lane); else passCount++;
        tick();
    endtask

    task automatic test_cnan();
        issue(2'b10, 1'b1, 1'b0, 2'b11, 64'h00000000_3F800000, 64'hFFFFFFFF_40000000,
              64'hFFFFFFFF_FFC00005, 64'hFFFFFFFF_3F800000, 1'b1);
        checkCount++;
        if (flagVec !== 12'b11_00_00_11_00_00) $display("[TB] FAIL cnan_flags: got %b expected %b", flagVec, 12'b11_00_00_11_00_00);
        else passCount++;
        checkCount++;
        if (qnanLane0 !== 53'h400000) $display("[TB] FAIL cnan_canon: got %h expected 400000", qnanLane0); else passCount++;
        checkCount++;
        if (qnanLane1 !== 53'hC00005) $display("[TB] FAIL cnan_neg_qnan: got %h expected C00005", qnanLane1); else passCount++;
        checkCount++;
        if (ex2_nv !== 1'b0) $display("[TB] FAIL cnan_nv: got %b expected 0", ex2_nv); else passCount++;
        tick();
    endtask

    task automatic test_div_misc();
        issue(2'b10, 1'b1, 1'b0, 2'b11, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000,
              64'hFFFFFFFF_7F800000, 64'hFFFFFFFF_40000000, 1'b1);
        checkCount++;
        if (flagVec !== 12'b11_00_10_01_01_00) $display("[TB] FAIL zz_infdiv_flags: got %b expected %b", flagVec, 12'b11_00_10_01_01_00);
        else passCount++;
        checkCount++;
        if (qnanLane0 !== 53'h400000) $display("[TB] FAIL zz_default_nan: got %h expected 400000", qnanLane0); else passCount++;
        issue(2'b10, 1'b1, 1'b0, 2'b11, 64'hFFFFFFFF_40000000, 64'hFFFFFFFF_7F800000,
              64'hFFFFFFFF_7F800001, 64'hFFFFFFFF_3F800000, 1'b1);
        checkCount++;
        if (flagVec !== 12'b11_01_00_10_10_00) $display("[TB] FAIL xinf_snan_flags: got %b expected %b", flagVec, 12'b11_01_00_10_10_00);
        else passCount++;
        checkCount++;
        if (qnanLane1 !== 53'h400001) $display("[TB] FAIL snan_single_payload: got %h expected 400001", qnanLane1); else passCount++;
        issue(2'b10, 1'b0, 1'b1, 2'b11, 64'hFFFFFFFF_80000000, 64'h0, 64'hFFFFFFFF_7F800000, 64'h0, 1'b1);
        checkCount++;
        if (flagVec !== 12'b11_01_10_00_00_00) $display("[TB] FAIL sqrt_zero_inf_flags: got %b expected %b", flagVec, 12'b11_01_10_00_00_00);
        else passCount++;
        tick();
    endtask

    task automatic test_bf16();
        issue(2'b01, 1'b0, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_BF80, 64'h0, 64'h0, 64'h0, 1'b1);
        checkCount++;
        if (ex2_vld !== 1'b1) $display("[TB] FAIL bf16_vld: got %b expected 1", ex2_vld); else passCount++;
`ifdef AQ_FDSU_SPECIAL_BF16_EN
        checkCount++;
        if ({flagVec, qnanLane0} !== {12'b01_00_00_01_01_00, 53'h40})
            $display("[TB] FAIL bf16_result: got %b/%h expected 010000010100/40", flagVec, qnanLane0);
        else passCount++;
`else
        checkCount++;
        if ({flagVec, qnanLane0} !== 65'h0) $display("[TB] FAIL bf16_reserved: got %b/%h expected 0", flagVec, qnanLane0);
        else passCount++;
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        clear_flags();
        ex2_rdy = 1'b0;
        issue(2'b10, 1'b1, 1'b0, 2'b01, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_00000000, 64'h0, 64'h0, 1'b1);
        drive(2'b10, 1'b1, 1'b0, 2'b01, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'h0, 64'h0, 1'b1);
        ex1_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if ({ex1_rdy, ex2_vld} !== 2'b01) $display("[TB] FAIL stall_hs[%0d]: got %b expected 01", i, {ex1_rdy, ex2_vld});
            else passCount++;
            checkCount++;
            if (flagVec !== 12'b01_00_01_00_00_01) $display("[TB] FAIL stall_hold[%0d]: got %b expected %b", i, flagVec, 12'b01_00_01_00_00_01);
            else passCount++;
        end
        ex2_rdy = 1'b1;
        tick();
        ex1_vld = 1'b0;
        checkCount++;
        if ({ex2_vld, flagVec} !== {1'b1, 12'b01_00_00_01_01_00})
            $display("[TB] FAIL b2b_second: got %b expected 1010000010100", {ex2_vld, flagVec});
        else passCount++;
        checkCount++;
        if ({fflags_nv_acc, fflags_dz_acc} !== 2'b01) $display("[TB] FAIL b2b_acc1: got %b expected 01", {fflags_nv_acc, fflags_dz_acc});
        else passCount++;
        tick();
        checkCount++;
        if ({ex2_vld, fflags_nv_acc, fflags_dz_acc} !== 3'b011)
            $display("[TB] FAIL b2b_acc2: got %b expected 011", {ex2_vld, fflags_nv_acc, fflags_dz_acc});
        else passCount++;
    endtask

    task automatic test_clr_concurrent();
        clear_flags();
        issue(2'b10, 1'b1, 1'b0, 2'b01, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_00000000, 64'h0, 64'h0, 1'b1);
        tick();
        checkCount++;
        if (fflags_dz_acc !== 1'b1) $display("[TB] FAIL clr_pre_dz: got %b expected 1", fflags_dz_acc); else passCount++;
        issue(2'b10, 1'b1, 1'b0, 2'b01, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'h0, 64'h0, 1'b1);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        checkCount++;
        if ({fflags_nv_acc, fflags_dz_acc} !== 2'b10)
            $display("[TB] FAIL clr_with_retire: got %b expected 10", {fflags_nv_acc, fflags_dz_acc});
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_flush();
        test_single_dz();
        test_half_sqrt();
        test_double_nan();
        test_cnan();
        test_div_misc();
        test_bf16();
        test_back_to_back();
        test_clr_concurrent();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
